// File: rtl/alu_pkg.sv
// Shared encodings and reset constants for the multi-cycle 4-bit lab ALU.
package alu_pkg;

    // Operation select on MODE
    localparam logic [1:0] MODE_ADD = 2'd0;
    localparam logic [1:0] MODE_AND = 2'd1;
    localparam logic [1:0] MODE_GT  = 2'd2;
    localparam logic [1:0] MODE_SHR = 2'd3;

    // Control states: IDLE takes a request, SHIFT runs the bit-serial shifter,
    // DONE holds the result until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Values forced by reset
    localparam state_t RST_STATE     = IDLE;
    localparam logic   RST_OUT_VALID = 1'b0;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ADD/AND/GT/SHR evaluator. The multi-cycle top only uses the
// SHR leg for a zero shift amount; the general shift keeps it usable as a
// stand-alone reference model.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [1:0]         i_mode,
    output logic [2*WIDTH-1:0] o_res
);

    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};

    // Select the operation and zero-extend the result to 2*WIDTH bits
    always_comb begin
        o_res = '0;
        case (i_mode)
            MODE_ADD: o_res[WIDTH:0]   = w_sum;
            MODE_AND: o_res[WIDTH-1:0] = i_a & i_b;
            MODE_GT:  o_res[0]         = (i_a > i_b);
            MODE_SHR: o_res[WIDTH-1:0] = i_a >> i_b;
            default:  o_res            = '0;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle, handshaked ALU. ADD/AND/GT (and SHR by zero) finish in one
// edge; SHR by B>0 shifts one bit per cycle for exactly B cycles.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [1:0]         MODE,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] OUT,
    output logic [CNT_W-1:0]   txn_cnt
);

    state_t               r_state;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_out;
    logic                 r_out_valid;
    logic [CNT_W-1:0]     r_txn_cnt;

    logic                 w_accept;
    logic                 w_single;
    logic [2*WIDTH-1:0]   w_core_res;
    logic [WIDTH-1:0]     w_acc_nxt;

    // in_ready is purely a state decode so it reads 1 while reset is held
    assign in_ready  = (r_state == IDLE);
    assign w_accept  = in_valid && in_ready;
    // Everything except a non-zero shift completes on the accepting edge
    assign w_single  = (MODE != MODE_SHR) || (B == '0);
    assign w_acc_nxt = r_acc >> 1;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .i_a    (A),
        .i_b    (B),
        .i_mode (MODE),
        .o_res  (w_core_res)
    );

    // Control FSM with bit-serial shifter, result register and handoff counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RST_STATE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out       <= '0;
            r_out_valid <= RST_OUT_VALID;
            r_txn_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_single) begin
                            r_out       <= w_core_res;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_acc   <= A;
                            r_cnt   <= B;
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    // No early exit on acc==0: latency is always B+1 edges
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt - WIDTH'(1);
                    if (r_cnt == WIDTH'(1)) begin
                        r_out       <= {{WIDTH{1'b0}}, w_acc_nxt};
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // OUT is held; counter wraps silently
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_txn_cnt   <= r_txn_cnt + CNT_W'(1);
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign OUT       = r_out;
    assign txn_cnt   = r_txn_cnt;

endmodule

// File: tb/tb_alu_mc.sv
// Directed and sweep bench for alu_mc, plus a CNT_W=4 instance for wrap.
module tb_alu_mc;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic [1:0] MODE;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] OUT;
    logic [15:0] txn_cnt;

    logic       in_valid4;
    logic       in_ready4;
    logic       out_valid4;
    logic       out_ready4;
    logic [7:0] out4;
    logic [3:0] txn_cnt4;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    alu_mc #(.WIDTH(4), .CNT_W(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .MODE      (MODE),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .OUT       (OUT),
        .txn_cnt   (txn_cnt)
    );

    alu_mc #(.WIDTH(4), .CNT_W(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .A         (4'd1),
        .B         (4'd2),
        .MODE      (2'd0),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .OUT       (out4),
        .txn_cnt   (txn_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] r;
        case (m)
            2'd0: r = 8'(a) + 8'(b);
            2'd1: r = 8'(a & b);
            2'd2: r = (a > b) ? 8'd1 : 8'd0;
            default: r = 8'(a) >> b;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait for the result, check latency/value, hand it off
    task automatic do_txn(input string tag, input logic [1:0] m, input logic [3:0] a,
                          input logic [3:0] b, input logic [7:0] exp,
                          input int exp_lat, input int stall);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 50) begin tick(); w++; end
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; A = a; B = b; MODE = m;
        tick();
        in_valid = 1'b0; A = 4'hx; B = 4'hx; MODE = 2'bxx;
        lat = 1;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_out"}, 32'(OUT), 32'(exp));
        for (int s = 0; s < stall; s++) tick();
        if (stall > 0) chk({tag, "_hold"}, 32'(OUT), 32'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt++;
        chk({tag, "_ovl"}, 32'(out_valid), 32'd0);
        chk({tag, "_cnt"}, 32'(txn_cnt), 32'(exp_cnt));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; MODE = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0;
        #1;
        chk("rst_ovl", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(OUT), 32'd0);
        chk("rst_cnt", 32'(txn_cnt), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        #12 rst_n = 1'b1;
        tick();

        // Reset mid-SHIFT: SHR 15>>10 accepted, reset 3 edges later
        in_valid = 1'b1; A = 4'd15; B = 4'd10; MODE = 2'd3;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("mid_rdy0", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ovl", 32'(out_valid), 32'd0);
        chk("mrst_out", 32'(OUT), 32'd0);
        chk("mrst_cnt", 32'(txn_cnt), 32'd0);
        chk("mrst_rdy", 32'(in_ready), 32'd1);
        #3 rst_n = 1'b1;
        tick();
        do_txn("post_add", 2'd0, 4'd1, 4'd1, 8'd2, 1, 0);

        // Directed single-cycle ops
        do_txn("add15", 2'd0, 4'd15, 4'd15, 8'd30, 1, 0);
        do_txn("and",   2'd1, 4'd12, 4'd10, 8'd8,  1, 1);
        do_txn("gt_eq", 2'd2, 4'd3,  4'd3,  8'd0,  1, 0);
        do_txn("gt",    2'd2, 4'd4,  4'd3,  8'd1,  1, 2);

        // Shift latency
        do_txn("shr2",  2'd3, 4'd12, 4'd2,  8'd3,  3,  0);
        do_txn("shr0",  2'd3, 4'd12, 4'd0,  8'd12, 1,  0);
        do_txn("shr15", 2'd3, 4'd15, 4'd15, 8'd0,  16, 0);

        // Backpressure: ADD 3+4 held while a new request waits
        in_valid = 1'b1; A = 4'd3; B = 4'd4; MODE = 2'd0;
        tick();
        A = 4'd1; B = 4'd2;
        chk("bp_ovl", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out", 32'(OUT), 32'd7);
            chk("bp_rdy", 32'(in_ready), 32'd0);
        end
        chk("bp_cnt0", 32'(txn_cnt), 32'(exp_cnt));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt++;
        chk("bp_cnt1", 32'(txn_cnt), 32'(exp_cnt));
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_acc", 32'(out_valid), 32'd1);
        chk("bp_out2", 32'(OUT), 32'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt++;
        chk("bp_cnt2", 32'(txn_cnt), 32'(exp_cnt));

        // Exhaustive sweep from a clean counter
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        exp_cnt = 0;
        tick();
        for (int m = 0; m < 4; m++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    do_txn("sweep", 2'(m), 4'(a), 4'(b), model(2'(m), 4'(a), 4'(b)),
                           (m == 3 && b != 0) ? b + 1 : 1, int'($urandom_range(0, 3)));
        chk("sweep_cnt", 32'(txn_cnt), 32'd1024);

        // Counter wrap on the 4-bit instance: 17 handoffs -> 1
        in_valid4 = 1'b1;
        out_ready4 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            int w;
            w = 0;
            while (!in_ready4 && w < 20) begin tick(); w++; end
            tick();
            chk("wrap_ovl", 32'(out_valid4), 32'd1);
            in_valid4 = (i != 16);
            tick();
        end
        in_valid4 = 1'b0;
        tick();
        chk("wrap_cnt", 32'(txn_cnt4), 32'd1);
        chk("wrap_out", 32'(out4), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
